// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the single-port memory.
interface mem_port_arbiter_if #(parameter int AW = 32);
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          i_req;
  logic [AW-1:0] i_addr;

  logic          ld_gnt, d_gnt, i_gnt;
  logic          d_stall, i_stall;
  logic          d_rvalid, i_rvalid;
  logic [31:0]   rdata;

  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  ld_req, ld_addr, ld_wdata, d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_rdata,
    output ld_gnt, d_gnt, i_gnt, d_stall, i_stall, d_rvalid, i_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_req, ld_addr, ld_wdata, d_req, d_we, d_addr, d_wdata, i_req, i_addr,
    input  ld_gnt, d_gnt, i_gnt, d_stall, i_stall, d_rvalid, i_rvalid, rdata
  );

  modport mem (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Loader/data/fetch arbiter for one single-port sync memory, with read-owner tracking.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] TAG_NONE  = 2'd0;
  localparam logic [1:0] TAG_DATA  = 2'd1;
  localparam logic [1:0] TAG_FETCH = 2'd2;

  if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be 1..3");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
    $error("mem_port_arbiter: MAX_WAIT must be 1..15");
  end

  logic ld_gnt, d_gnt, i_gnt;
  logic promote;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] wait_q, wait_d;

  assign promote = (wait_q == 4'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (!bus.i_req || i_gnt) wait_d = '0;
    else if (!promote)       wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign promote = 1'b0;
`endif

  // Loader locks out both other ports, even a promoted fetch.
  always_comb begin
    ld_gnt = bus.ld_req;
    i_gnt  = !bus.ld_req && bus.i_req && (!bus.d_req || promote);
    d_gnt  = !bus.ld_req && bus.d_req && !i_gnt;
  end

  assign bus.ld_gnt  = ld_gnt;
  assign bus.d_gnt   = d_gnt;
  assign bus.i_gnt   = i_gnt;
  assign bus.d_stall = bus.d_req && !d_gnt;
  assign bus.i_stall = bus.i_req && !i_gnt;

  logic [AW-1:0] addr_mux;
  logic [31:0]   wdata_mux;
  logic          we_mux;

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    if (ld_gnt) begin
      addr_mux  = bus.ld_addr;
      wdata_mux = bus.ld_wdata;
      we_mux    = 1'b1;
    end else if (d_gnt) begin
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
      we_mux    = bus.d_we;
    end else if (i_gnt) begin
      addr_mux  = bus.i_addr;
    end
  end

  // Grants still follow requests during reset, but nothing reaches the memory.
  assign bus.mem_en    = rst_n && (ld_gnt || d_gnt || i_gnt);
  assign bus.mem_we    = rst_n && we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  logic [1:0]                tag_in;
  logic [MEM_LAT-1:0][1:0]   tag_q, tag_d;

  always_comb begin
    tag_in = TAG_NONE;
    if (d_gnt && !bus.d_we) tag_in = TAG_DATA;
    else if (i_gnt)         tag_in = TAG_FETCH;
  end

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = tag_in;
    for (int k = 1; k < MEM_LAT; k++) tag_d[k] = tag_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  logic d_rv, i_rv;
  assign d_rv         = (tag_q[MEM_LAT-1] == TAG_DATA);
  assign i_rv         = (tag_q[MEM_LAT-1] == TAG_FETCH);
  assign bus.d_rvalid = d_rv;
  assign bus.i_rvalid = i_rv;
  assign bus.rdata    = (d_rv || i_rv) ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: reads push expected responses, a monitor pops them.
module tb_mem_port_arbiter;
  localparam int AW       = 32;
  localparam int MEM_LAT  = 2;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(AW)) bus();

  mem_port_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'h5A00_0000 ^ (32'(k) * 32'h0001_0101);
  endfunction

  // Memory model: sync write, MEM_LAT-cycle read pipeline.
  logic [31:0] mem     [0:255];
  logic        written [0:255];
  logic [31:0] rpipe   [0:MEM_LAT-1];

  initial for (int k = 0; k < 256; k++) written[k] = 1'b0;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:0]]     <= bus.mem_wdata;
      written[bus.mem_addr[7:0]] <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we)
      rpipe[0] <= written[bus.mem_addr[7:0]] ? mem[bus.mem_addr[7:0]] : init_word(int'(bus.mem_addr[7:0]));
    else
      rpipe[0] <= 32'hBAD0_BAD0;
    for (int k = 1; k < MEM_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign bus.mem_rdata = rpipe[MEM_LAT-1];

  logic [31:0] shadow [0:255];
  initial for (int k = 0; k < 256; k++) shadow[k] = init_word(k);

  typedef struct {
    int          due;
    logic [1:0]  rv;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic ld, input logic d, input logic we, input logic i);
    bus.ld_req = ld;
    bus.d_req  = d;
    bus.d_we   = we;
    bus.i_req  = i;
  endtask

  // Checks grants, stalls and memory drive for the current cycle; records expected reads.
  task automatic expect_cyc(input string tag, input logic [2:0] egnt, input logic [AW-1:0] eaddr,
                            input logic [31:0] ewd);
    logic eme, ewe;
    logic [1:0] estall;
    eme    = rst_n && (egnt != 3'b000);
    ewe    = egnt[2] || (egnt[1] && bus.d_we);
    estall = {bus.d_req && !egnt[1], bus.i_req && !egnt[0]};
    chk({tag, "_gnt"},   32'({bus.ld_gnt, bus.d_gnt, bus.i_gnt}), 32'(egnt));
    chk({tag, "_stall"}, 32'({bus.d_stall, bus.i_stall}), 32'(estall));
    chk({tag, "_en"},    32'(bus.mem_en), 32'(eme));
    if (eme) begin
      chk({tag, "_we"},   32'(bus.mem_we), 32'(ewe));
      chk({tag, "_addr"}, bus.mem_addr, eaddr);
      if (ewe) begin
        chk({tag, "_wdata"}, bus.mem_wdata, ewd);
        shadow[eaddr[7:0]] = ewd;
      end else if (egnt[1]) begin
        q.push_back('{cyc + MEM_LAT, 2'b10, shadow[eaddr[7:0]]});
      end else begin
        q.push_back('{cyc + MEM_LAT, 2'b01, shadow[eaddr[7:0]]});
      end
    end else if (egnt == 3'b000) begin
      chk({tag, "_idle_addr"}, bus.mem_addr, 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("rvalid", 32'({bus.d_rvalid, bus.i_rvalid}), 32'(q[0].rv));
        chk("rdata",  bus.rdata, q[0].data);
        void'(q.pop_front());
      end else begin
        chk("rvalid_idle", 32'({bus.d_rvalid, bus.i_rvalid}), 32'd0);
        chk("rdata_idle",  bus.rdata, 32'd0);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_wdata = '0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.i_addr   = '0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset with everything requesting: grants follow, memory stays off.
    set_req(1'b1, 1'b1, 1'b0, 1'b1);
    bus.ld_addr = 32'h80; bus.ld_wdata = 32'hFEED_0001;
    bus.d_addr  = 32'h10; bus.i_addr   = 32'h04;
    #1;
    expect_cyc("rst", 3'b100, '0, '0);
    chk("rst_rvalid", 32'({bus.d_rvalid, bus.i_rvalid}), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    expect_cyc("rel", 3'b100, 32'h80, 32'hFEED_0001);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    expect_cyc("idle0", 3'b000, '0, '0);
    tick();

    // Data outranks fetch.
    set_req(1'b0, 1'b1, 1'b0, 1'b1);
    bus.d_addr = 32'h10; bus.i_addr = 32'h04; bus.d_wdata = 32'h1111_2222;
    #1;
    expect_cyc("prio", 3'b010, 32'h10, '0);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (MEM_LAT + 1) begin #1; expect_cyc("idle1", 3'b000, '0, '0); tick(); end

    // Fetch under continuous data traffic.
    bus.i_addr = 32'h08;
    for (int k = 0; k < 10; k++) begin
      set_req(1'b0, 1'b1, 1'b0, 1'b1);
      bus.d_addr = 32'h20 + 32'(k);
      #1;
`ifdef ARB_STARVE_GUARD_EN
      if (k % 5 == 4) expect_cyc("promo", 3'b001, 32'h08, '0);
      else            expect_cyc("promo", 3'b010, 32'h20 + 32'(k), '0);
`else
      expect_cyc("starve", 3'b010, 32'h20 + 32'(k), '0);
`endif
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1; expect_cyc("idle2", 3'b000, '0, '0); tick();

    // Loader lock: eight writes, data and fetch both stalled.
    for (int k = 0; k < 8; k++) begin
      set_req(1'b1, 1'b1, 1'b0, 1'b1);
      bus.ld_addr  = 32'h40 + 32'(k);
      bus.ld_wdata = 32'hA000_0000 + 32'(k * 7);
      #1;
      expect_cyc("ldlock", 3'b100, 32'h40 + 32'(k), 32'hA000_0000 + 32'(k * 7));
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1; expect_cyc("idle3", 3'b000, '0, '0); tick();

    // Read back loader data, a data write, then alternating d/i reads.
    set_req(1'b0, 1'b1, 1'b1, 1'b0);
    bus.d_addr = 32'h33; bus.d_wdata = 32'hC0FF_EE33;
    #1; expect_cyc("dwr", 3'b010, 32'h33, 32'hC0FF_EE33); tick();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        set_req(1'b0, 1'b1, 1'b0, 1'b0);
        bus.d_addr = (k == 0) ? 32'h40 : (k == 2) ? 32'h47 : 32'h30 + 32'(k);
        #1; expect_cyc("alt_d", 3'b010, bus.d_addr, '0);
      end else begin
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        bus.i_addr = (k == 1) ? 32'h33 : 32'h50 + 32'(k);
        #1; expect_cyc("alt_i", 3'b001, bus.i_addr, '0);
      end
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (MEM_LAT + 1) begin #1; expect_cyc("idle4", 3'b000, '0, '0); tick(); end

    // Fetch in flight, then reset: its response must vanish.
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    bus.i_addr = 32'h05;
    #1; expect_cyc("mf_rd", 3'b001, 32'h05, '0); tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    q.delete();
    #1; expect_cyc("mf_rst", 3'b000, '0, '0); tick();
    chk("mf_rvalid", 32'({bus.d_rvalid, bus.i_rvalid}), 32'd0);
    tick();
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    bus.i_addr = 32'h06;
    #1; expect_cyc("post_rst", 3'b001, 32'h06, '0); tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (MEM_LAT + 2) begin #1; expect_cyc("drain", 3'b000, '0, '0); tick(); end

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between three requesters: the instruction loader, the MEM-stage data port, and the IF-stage fetch port. Selects one requester per cycle, drives the memory, tracks which requester owns each in-flight read, and returns read data with a per-requester valid. Produces stall signals that the pipeline's hazard logic uses to freeze IF/ID and EX/MEM while a port is waiting.

## Interface
Parameters:
- AW, 32: address width.
- MEM_LAT, 1: memory read latency in cycles; legal values 1..3.
- MAX_WAIT, 4: consecutive denied fetch cycles before fetch is promoted above data; legal values 1..15.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- ld_req  in  1  loader write request.
- ld_addr  in  AW  loader address.
- ld_wdata  in  32  loader write data.
- d_req  in  1  data request.
- d_we  in  1  data write (1) or read (0).
- d_addr  in  AW  data address.
- d_wdata  in  32  data write data.
- i_req  in  1  fetch read request.
- i_addr  in  AW  fetch address.
- ld_gnt, d_gnt, i_gnt  out  1 each  grants; combinational, one-hot or all zero.
- d_stall, i_stall  out  1 each  req & ~gnt for that port.
- d_rvalid, i_rvalid  out  1 each  read data valid for that port.
- rdata  out  32  read data; meaningful only while a rvalid is high.
- mem_en, mem_we  out  1 each  memory enable / write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after an enabled read.

## Operation
- Priority: loader > data > fetch by default.
- Promotion: the wait counter (4 bits) increments on each cycle with i_req=1 and i_gnt=0. It saturates at MAX_WAIT and clears on i_gnt=1 or i_req=0. While the counter equals MAX_WAIT, fetch outranks data. The loader still wins. The counter clears on the resulting fetch grant.
- Memory drive: the granted port's address, data and write are muxed onto mem_*. mem_en = |gnt. mem_we = ld_gnt | (d_gnt & d_we). Fetch is always a read. With no grant, mem_en=0, mem_we=0, and addr/wdata=0.
- Owner pipeline: MEM_LAT-deep shift register of 2-bit tags (NONE, DATA, FETCH). Each cycle the tag for the current granted read enters, or NONE for writes and idle cycles.
- Response: at the pipeline tail, tag DATA gives d_rvalid=1 and tag FETCH gives i_rvalid=1. rdata = mem_rdata when either is high, otherwise 0.
- Back-to-back grants are legal every cycle. There is no outstanding-request limit beyond MEM_LAT.
- Loader lock: while ld_req=1, data and fetch are never granted, including under promotion. Both stall.
- Simultaneous: all three requesting with the counter below MAX_WAIT gives ld_gnt only.

## Timing
- Grants and stalls are combinational from the req inputs and the registered counter, in the same cycle.
- A read granted in cycle N gives rvalid in cycle N+MEM_LAT. A write takes effect at the memory edge ending cycle N.
- Reset (Reset=0): the counter goes to 0 and all tags go to NONE. Every registered output and rvalid goes to 0 immediately.
- Grants follow the req inputs even during reset. mem_en is forced to 0 while Reset=0.
- Reset mid-operation: in-flight read tags are discarded. No rvalid is produced for reads issued before reset.
- Requesters must hold req, addr and data stable until their gnt. Dropping a request before its grant is legal and is ignored.

## Configuration
- ARB_STARVE_GUARD_EN defined: the wait counter and promotion are built as described above.
- ARB_STARVE_GUARD_EN undefined: no counter is built and priority is strictly loader > data > fetch. Fetch can starve indefinitely under continuous data requests.

## Test plan
- Reset: Reset=0 with all reqs=1 -> mem_en=0, all rvalid=0. Release Reset -> ld_gnt=1 in the first cycle.
- Priority: d_req=1 and i_req=1 with d_we=0, d_addr=0x10, i_addr=0x04 -> d_gnt=1, i_stall=1, mem_addr=0x10. d_rvalid=1 with mem_rdata MEM_LAT cycles later, and i_rvalid stays 0.
- Starvation (ARB_STARVE_GUARD_EN, MAX_WAIT=4): d_req held at 1 with i_req=1 -> i_gnt=1 in the 5th cycle, d_gnt=0 that cycle. d_gnt resumes the next cycle with the counter at 0.
- Loader lock: ld_req=1 for 8 cycles with d_req and i_req at 1 -> 8 writes with mem_we=1 to ld_addr values. d_stall=1 and i_stall=1 throughout, with no promotion grant.
- Pipelined reads (MEM_LAT=2): alternating data and fetch reads each cycle -> rvalids alternate d, i, d, i starting 2 cycles after the first grant. Each rdata matches the memory contents at its address.
- Mid-flight reset: grant a fetch read, then assert Reset=0 one cycle later -> i_rvalid never asserts for that read. The first post-reset read returns correctly.
